// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath / data memory.
// master = controller side, slave = datapath/memory side.
interface mc_controller_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        dm_ready;
  logic        ir_we;
  logic        pc_we;
  logic        reg_write;
  logic        dm_req;
  logic        mem_write;
  logic        alu_src;
  logic [1:0]  alu_ctr;
  logic        ext_op;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [2:0]  npc_sel;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  modport master (
    input  op, funct, zero, dm_ready,
    output ir_we, pc_we, reg_write, dm_req, mem_write, alu_src, alu_ctr, ext_op,
           reg_dst, mem_to_reg, npc_sel, state, trap, cycle_cnt, instr_cnt
  );

  modport slave (
    output op, funct, zero, dm_ready,
    input  ir_we, pc_we, reg_write, dm_req, mem_write, alu_src, alu_ctr, ext_op,
           reg_dst, mem_to_reg, npc_sel, state, trap, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS datapath, with illegal-op and memory-timeout trap.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_NOP, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL, I_ILLEGAL
  } instr_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_n;
  instr_t     instr;
  logic [7:0] tmo_q, tmo_n;
  logic       ir_we, pc_we, reg_write, dm_req, mem_write, alu_src, ext_op;
  logic [1:0] alu_ctr, reg_dst, mem_to_reg;
  logic [2:0] npc_sel;

  always_comb begin
    instr = I_ILLEGAL;
    case (bus.op)
      6'b000000: begin
        case (bus.funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          6'b000000: instr = I_NOP;
          default:   instr = I_ILLEGAL;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000011: instr = I_JAL;
      default:   instr = I_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_n;
      tmo_q   <= tmo_n;
    end
  end

  // pc_we fires in the last state of each sequence; for sw that is the MEM cycle where dm_ready is seen.
  always_comb begin
    state_n    = state_q;
    tmo_n      = tmo_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_write  = 1'b0;
    dm_req     = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_ctr    = 2'b00;
    ext_op     = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    npc_sel    = 3'b000;
    case (state_q)
      FETCH: begin
        ir_we   = 1'b1;
        state_n = DECODE;
      end
      DECODE: state_n = (instr == I_ILLEGAL) ? TRAP : EXE;
      EXE: begin
        state_n = FETCH;
        case (instr)
          I_ADDU: state_n = WB;
          I_SUBU: begin alu_ctr = 2'b01; state_n = WB; end
          I_ORI:  begin alu_src = 1'b1; alu_ctr = 2'b10; state_n = WB; end
          I_LUI:  begin alu_src = 1'b1; alu_ctr = 2'b11; state_n = WB; end
          I_JAL:  state_n = WB;
          I_LW, I_SW: begin
            alu_src = 1'b1;
            ext_op  = 1'b1;
            tmo_n   = 8'd0;
            state_n = MEM;
          end
          I_BEQ: begin
            alu_ctr = 2'b01;
            pc_we   = 1'b1;
            npc_sel = bus.zero ? 3'b001 : 3'b000;
          end
          I_JR:   begin pc_we = 1'b1; npc_sel = 3'b011; end
          I_NOP:  pc_we = 1'b1;
          default: ;
        endcase
      end
      MEM: begin
        dm_req    = 1'b1;
        mem_write = (instr == I_SW);
        if (bus.dm_ready) begin
          if (instr == I_SW) begin
            pc_we   = 1'b1;
            state_n = FETCH;
          end else begin
            state_n = WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_n = TRAP;
        end else begin
          tmo_n = tmo_q + 8'd1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        state_n   = FETCH;
        case (instr)
          I_ADDU, I_SUBU: reg_dst = 2'b01;
          I_LW:           mem_to_reg = 2'b01;
          I_LUI:          mem_to_reg = 2'b11;
          I_JAL: begin
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            npc_sel    = 3'b010;
          end
          default: ;
        endcase
      end
      TRAP:    state_n = TRAP;
      default: state_n = TRAP;
    endcase
    // A reset cycle aborts whatever is in flight: nothing may be written.
    if (reset) begin
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_write  = 1'b0;
      dm_req     = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      alu_ctr    = 2'b00;
      ext_op     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      npc_sel    = 3'b000;
    end
  end

  assign bus.ir_we      = ir_we;
  assign bus.pc_we      = pc_we;
  assign bus.reg_write  = reg_write;
  assign bus.dm_req     = dm_req;
  assign bus.mem_write  = mem_write;
  assign bus.alu_src    = alu_src;
  assign bus.alu_ctr    = alu_ctr;
  assign bus.ext_op     = ext_op;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.npc_sel    = npc_sel;
  assign bus.state      = state_q;
  assign bus.trap       = (state_q == TRAP);

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (pc_we) instr_q <= instr_q + 32'd1;
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
`else
  assign bus.cycle_cnt = 32'h0;
  assign bus.instr_cnt = 32'h0;
`endif

endmodule
